// File: rtl/systolic_mm_sequencer.sv
// Sequencer for a 3x3 systolic matrix multiplier computing C = A x B.
// It holds the host-written operands, drives the array feeds and latches the results for readback.
module systolic_mm_sequencer #(
    parameter int DW      = 32,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              wr_reject,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [3:0]        rd_addr,
    output logic [2*DW-1:0]   rd_data,
    output logic              arr_clr,
    output logic [DW-1:0]     arr_a1,
    output logic [DW-1:0]     arr_a2,
    output logic [DW-1:0]     arr_a3,
    output logic [DW-1:0]     arr_b1,
    output logic [DW-1:0]     arr_b2,
    output logic [DW-1:0]     arr_b3,
    input  logic [2*DW-1:0]   arr_c1,
    input  logic [2*DW-1:0]   arr_c2,
    input  logic [2*DW-1:0]   arr_c3,
    input  logic [2*DW-1:0]   arr_c4,
    input  logic [2*DW-1:0]   arr_c5,
    input  logic [2*DW-1:0]   arr_c6,
    input  logic [2*DW-1:0]   arr_c7,
    input  logic [2*DW-1:0]   arr_c8,
    input  logic [2*DW-1:0]   arr_c9
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Drain lasts 3 + MAC_LAT cycles so the last skewed product reaches every accumulator.
    localparam logic [2:0] DRAIN_LAST = 3'(2 + MAC_LAT);

    logic [2:0]      state;
    logic [2:0]      cnt;
    logic [DW-1:0]   a_mem [0:2][0:2];
    logic [DW-1:0]   b_mem [0:2][0:2];
    logic [2*DW-1:0] res   [0:8];
    logic [1:0]      wr_row;
    logic [1:0]      wr_col;
    logic [1:0]      k;
    logic            wr_ok;

    assign wr_row  = wr_addr[3:2];
    assign wr_col  = wr_addr[1:0];
    assign wr_ok   = (state == S_IDLE) && (wr_row != 2'd3) && (wr_col != 2'd3);
    assign k       = cnt[1:0];

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign arr_clr = (state == S_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state <= S_FEED;
                    cnt   <= 3'd0;
                end
                S_FEED: begin
                    if (cnt == 3'd2) begin
                        state <= S_DRAIN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_CAPTURE: state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
            wr_reject <= 1'b0;
        end else begin
            wr_reject <= wr_en && !wr_ok;
            if (wr_en && wr_ok) begin
                if (wr_sel) begin
                    b_mem[wr_row][wr_col] <= wr_data;
                end else begin
                    a_mem[wr_row][wr_col] <= wr_data;
                end
            end
        end
    end

    // The bank only changes in CAPTURE, so reads during a run see the previous results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                res[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (state == S_CAPTURE) begin
                res[0] <= arr_c1;
                res[1] <= arr_c2;
                res[2] <= arr_c3;
                res[3] <= arr_c4;
                res[4] <= arr_c5;
                res[5] <= arr_c6;
                res[6] <= arr_c7;
                res[7] <= arr_c8;
                res[8] <= arr_c9;
            end
            rd_data <= (rd_addr <= 4'd8) ? res[rd_addr] : '0;
        end
    end

    always_comb begin
        arr_a1 = '0;
        arr_a2 = '0;
        arr_a3 = '0;
        arr_b1 = '0;
        arr_b2 = '0;
        arr_b3 = '0;
        if (state == S_FEED) begin
            arr_a1 = a_mem[0][k];
            arr_a2 = a_mem[1][k];
            arr_a3 = a_mem[2][k];
            arr_b1 = b_mem[k][0];
            arr_b2 = b_mem[k][1];
            arr_b3 = b_mem[k][2];
        end
    end

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// Self-checking bench for systolic_mm_sequencer with a behavioural 3x3 accumulator array model.
module tb_systolic_mm_sequencer;

    localparam int DW      = 32;
    localparam int MAC_LAT = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_en = 1'b0;
    logic            wr_sel = 1'b0;
    logic [3:0]      wr_addr = 4'd0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_reject;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [3:0]      rd_addr = 4'd0;
    logic [2*DW-1:0] rd_data;
    logic            arr_clr;
    logic [DW-1:0]   arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3;
    logic [2*DW-1:0] arr_c1, arr_c2, arr_c3, arr_c4, arr_c5, arr_c6, arr_c7, arr_c8, arr_c9;

    systolic_mm_sequencer #(.DW(DW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .wr_reject(wr_reject),
        .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .arr_clr(arr_clr),
        .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_a3(arr_a3),
        .arr_b1(arr_b1), .arr_b2(arr_b2), .arr_b3(arr_b3),
        .arr_c1(arr_c1), .arr_c2(arr_c2), .arr_c3(arr_c3),
        .arr_c4(arr_c4), .arr_c5(arr_c5), .arr_c6(arr_c6),
        .arr_c7(arr_c7), .arr_c8(arr_c8), .arr_c9(arr_c9)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural array: one accumulating MAC per output, MAC_LAT = 1.
    logic [2*DW-1:0] acc [0:2][0:2];
    logic [DW-1:0]   fa  [0:2];
    logic [DW-1:0]   fb  [0:2];
    assign fa[0] = arr_a1;
    assign fa[1] = arr_a2;
    assign fa[2] = arr_a3;
    assign fb[0] = arr_b1;
    assign fb[1] = arr_b2;
    assign fb[2] = arr_b3;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (arr_clr) acc[i][j] <= '0;
                else         acc[i][j] <= acc[i][j] + ({32'd0, fa[i]} * {32'd0, fb[j]});
            end
        end
    end

    assign arr_c1 = acc[0][0];
    assign arr_c2 = acc[0][1];
    assign arr_c3 = acc[0][2];
    assign arr_c4 = acc[1][0];
    assign arr_c5 = acc[1][1];
    assign arr_c6 = acc[1][2];
    assign arr_c7 = acc[2][0];
    assign arr_c8 = acc[2][1];
    assign arr_c9 = acc[2][2];

    int tests = 0;
    int failures = 0;

    logic [2*DW-1:0] rdQ[$];
    int              rdTagQ[$];
    bit              rejQ[$];
    int              doneQ[$];
    bit              rdIssue = 1'b0;
    bit              wrIssue = 1'b0;
    bit              rdPend = 1'b0;
    bit              wrPend = 1'b0;
    bit              chkFeed = 1'b0;
    int              startEdge = 0;
    logic [DW-1:0]   eA [3][3];
    logic [DW-1:0]   eB [3][3];

    // Every comparison in the bench funnels through here so the counts stay consistent.
    task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a read, reject or done response.
    always @(negedge clk) begin
        int rel;
        logic [191:0] feedExp;
        logic [191:0] feedAct;
        if (!rst) begin
            rdPend = 1'b0;
            wrPend = 1'b0;
        end else begin
            if (rdPend && rdQ.size() > 0)
                checkOutput($sformatf("rd[%0d]", rdTagQ.pop_front()), rd_data, rdQ.pop_front());
            rdPend = rdIssue;
            if (wrPend && rejQ.size() > 0)
                checkOutput("wr_reject", wr_reject, rejQ.pop_front());
            wrPend = wrIssue;
            if (done) begin
                if (doneQ.size() == 0) checkOutput("unexpected done", 1, 0);
                else checkOutput("done latency", cyc - startEdge, doneQ.pop_front());
            end
            if (chkFeed && busy) begin
                rel = cyc - startEdge;
                feedExp = '0;
                if (rel >= 1 && rel <= 3)
                    feedExp = {eA[0][rel-1], eA[1][rel-1], eA[2][rel-1],
                               eB[rel-1][0], eB[rel-1][1], eB[rel-1][2]};
                feedAct = {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3};
                checkOutput($sformatf("arr_clr rel%0d", rel), arr_clr, rel == 0);
                checkOutput($sformatf("feed rel%0d", rel), feedAct, feedExp);
            end
        end
    end

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic applyStimulus(input bit sel, input int row, input int col,
                                 input logic [DW-1:0] data, input bit expRej);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = {2'(row), 2'(col)};
        wr_data = data;
        wrIssue = 1'b1;
        rejQ.push_back(expRej);
        @(posedge clk); #1;
        wr_en   = 1'b0;
        wrIssue = 1'b0;
    endtask

    task automatic readCheck(input int addr, input logic [2*DW-1:0] expected);
        rd_addr = 4'(addr);
        rdIssue = 1'b1;
        rdQ.push_back(expected);
        rdTagQ.push_back(addr);
        @(posedge clk); #1;
        rdIssue = 1'b0;
    endtask

    task automatic readAll(input logic [2*DW-1:0] e [9]);
        for (int a = 0; a < 9; a++) readCheck(a, e[a]);
    endtask

    task automatic startRun(input bit expectDone, input bit doWr, input bit sel,
                            input int row, input int col, input logic [DW-1:0] data);
        start = 1'b1;
        if (expectDone) doneQ.push_back(9);
        if (doWr) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_addr = {2'(row), 2'(col)};
            wr_data = data;
            wrIssue = 1'b1;
            rejQ.push_back(1'b0);
        end
        @(posedge clk); #1;
        startEdge = cyc;
        start   = 1'b0;
        wr_en   = 1'b0;
        wrIssue = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("busy drops", ok, 1'b1);
    endtask

    task automatic loadIdentityAndSeq(input bit withStart);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, i, i, 32'd1, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!(withStart && r == 2 && c == 2))
                    applyStimulus(1'b1, r, c, 32'(3*r + c + 1), 1'b0);
    endtask

    initial begin
        logic [2*DW-1:0] eIdent [9];
        logic [2*DW-1:0] eGen   [9];
        logic [2*DW-1:0] eOvf   [9];
        logic [2*DW-1:0] eZero  [9];
        eIdent = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd9};
        eGen   = '{64'd30, 64'd24, 64'd18, 64'd84, 64'd69, 64'd54, 64'd138, 64'd114, 64'd90};
        for (int i = 0; i < 9; i++) begin
            eOvf[i]  = 64'hFFFF_FFFA_0000_0003;
            eZero[i] = 64'd0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy/done/clr/rej", {busy, done, arr_clr, wr_reject}, 4'b0000);
        checkOutput("reset feeds", {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 192'd0);
        checkOutput("reset rd_data", rd_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Identity: last B write shares the cycle with start
        loadIdentityAndSeq(1'b1);
        startRun(1'b1, 1'b1, 1'b1, 2, 2, 32'd9);
        waitIdle();
        readAll(eIdent);
        readCheck(12, 64'd0);

        // General product with feed/clear tracking
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                eA[r][c] = 32'(3*r + c + 1);
                eB[r][c] = 32'(9 - (3*r + c));
                applyStimulus(1'b0, r, c, eA[r][c], 1'b0);
                applyStimulus(1'b1, r, c, eB[r][c], 1'b0);
            end
        chkFeed = 1'b1;
        startRun(1'b1, 1'b0, 1'b0, 0, 0, '0);
        waitIdle();
        chkFeed = 1'b0;
        readAll(eGen);

        // Overflow, plus old/new result visibility around CAPTURE
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1'b0, r, c, 32'hFFFF_FFFF, 1'b0);
                applyStimulus(1'b1, r, c, 32'hFFFF_FFFF, 1'b0);
            end
        startRun(1'b1, 1'b0, 1'b0, 0, 0, '0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        readCheck(0, 64'd30);
        readCheck(0, 64'hFFFF_FFFA_0000_0003);
        waitIdle();
        readAll(eOvf);

        // Protocol: bad addresses, write while busy, start while busy, back-to-back start
        applyStimulus(1'b0, 3, 0, 32'd0, 1'b1);
        applyStimulus(1'b1, 0, 3, 32'd0, 1'b1);
        startRun(1'b1, 1'b0, 1'b0, 0, 0, '0);
        applyStimulus(1'b0, 0, 0, 32'd0, 1'b1);
        pulseStart();
        repeat (2) begin
            @(posedge clk); #1;
        end
        pulseStart();
        waitIdle();
        startRun(1'b1, 1'b0, 1'b0, 0, 0, '0);
        waitIdle();
        repeat (15) begin
            @(posedge clk); #1;
        end
        readAll(eOvf);

        // Reset in the middle of FEED
        startRun(1'b0, 1'b0, 1'b0, 0, 0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midreset busy/done/clr/rej", {busy, done, arr_clr, wr_reject}, 4'b0000);
        checkOutput("midreset feeds", {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 192'd0);
        checkOutput("midreset rd_data", rd_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        readAll(eZero);
        loadIdentityAndSeq(1'b0);
        startRun(1'b1, 1'b0, 1'b0, 0, 0, '0);
        waitIdle();
        readAll(eIdent);

        repeat (15) begin
            @(posedge clk); #1;
        end
        checkOutput("outstanding done", doneQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
